// File: rtl/rc4_pkg.sv
// Shared types, encodings and decode helpers for the RC4 key search controller.
package rc4_pkg;

    localparam int KEY_W_DEFAULT = 24;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_INIT_GO   = 4'd1,
        ST_INIT_WAIT = 4'd2,
        ST_KSA_GO    = 4'd3,
        ST_KSA_WAIT  = 4'd4,
        ST_PRGA_GO   = 4'd5,
        ST_PRGA_WAIT = 4'd6,
        ST_FOUND     = 4'd7,
        ST_FAIL      = 4'd8
    } state_t;

    localparam logic [1:0] MEM_INIT = 2'd0;
    localparam logic [1:0] MEM_KSA  = 2'd1;
    localparam logic [1:0] MEM_PRGA = 2'd2;
    localparam logic [1:0] MEM_NONE = 2'd3;

    function automatic logic [1:0] mem_sel_of(input state_t st);
        case (st)
            ST_INIT_GO, ST_INIT_WAIT: return MEM_INIT;
            ST_KSA_GO,  ST_KSA_WAIT:  return MEM_KSA;
            ST_PRGA_GO, ST_PRGA_WAIT: return MEM_PRGA;
            default:                  return MEM_NONE;
        endcase
    endfunction

    function automatic logic is_busy(input state_t st);
        case (st)
            ST_INIT_GO, ST_INIT_WAIT,
            ST_KSA_GO,  ST_KSA_WAIT,
            ST_PRGA_GO, ST_PRGA_WAIT: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/key_counter.sv
// Key register for the search: loads the first key, steps by one and flags the
// last key so the controller can stop without wrapping.
module key_counter
    import rc4_pkg::*;
#(
    parameter int              KEY_W     = KEY_W_DEFAULT,
    parameter logic [KEY_W-1:0] KEY_FIRST = 24'h000000,
    parameter logic [KEY_W-1:0] KEY_LAST  = 24'h3FFFFF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             inc,
    output logic [KEY_W-1:0] key,
    output logic             is_last
);

    assign is_last = (key == KEY_LAST);

    // The increment is suppressed on the last key so the register can never wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key <= KEY_FIRST;
        end else if (load) begin
            key <= KEY_FIRST;
        end else if (inc && !is_last) begin
            key <= key + KEY_W'(1);
        end
    end

endmodule

// File: rtl/key_search_ctrl.sv
// Sequences the init, KSA and PRGA engines over a range of keys until the
// decrypted message is accepted or the range is exhausted.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for start
// INIT_GO    | one-cycle init_start launch, S-memory owned by init
// INIT_WAIT  | waiting for init_done
// KSA_GO     | one-cycle ksa_start launch, S-memory owned by KSA
// KSA_WAIT   | waiting for ksa_done
// PRGA_GO    | one-cycle prga_start launch, S-memory owned by PRGA
// PRGA_WAIT  | waiting for prga_done, then pass/next key/fail
// FOUND      | key holds the accepted key
// FAIL       | every key up to KEY_LAST was rejected
module key_search_ctrl
    import rc4_pkg::*;
#(
    parameter int              KEY_W     = KEY_W_DEFAULT,
    parameter logic [KEY_W-1:0] KEY_FIRST = 24'h000000,
    parameter logic [KEY_W-1:0] KEY_LAST  = 24'h3FFFFF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    output logic [KEY_W-1:0] key,
    output logic             init_start,
    output logic             ksa_start,
    output logic             prga_start,
    input  logic             init_done,
    input  logic             ksa_done,
    input  logic             prga_done,
    input  logic             prga_pass,
    output logic [1:0]       mem_sel,
    output logic             busy,
    output logic             found,
    output logic             fail
);

    state_t     state;
    state_t     state_nx;
    logic       key_load;
    logic       key_inc;
    logic       key_is_last;
    logic       init_start_nx;
    logic       ksa_start_nx;
    logic       prga_start_nx;
    logic [1:0] mem_sel_nx;
    logic       busy_nx;
    logic       found_nx;
    logic       fail_nx;

    key_counter #(
        .KEY_W    (KEY_W),
        .KEY_FIRST(KEY_FIRST),
        .KEY_LAST (KEY_LAST)
    ) u_key_counter (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (key_load),
        .inc    (key_inc),
        .key    (key),
        .is_last(key_is_last)
    );

    // Outputs are registered from the next-state decode so they move on the
    // same edge as the state itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            init_start <= 1'b0;
            ksa_start  <= 1'b0;
            prga_start <= 1'b0;
            mem_sel    <= MEM_NONE;
            busy       <= 1'b0;
            found      <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state      <= state_nx;
            init_start <= init_start_nx;
            ksa_start  <= ksa_start_nx;
            prga_start <= prga_start_nx;
            mem_sel    <= mem_sel_nx;
            busy       <= busy_nx;
            found      <= found_nx;
            fail       <= fail_nx;
        end
    end

    always_comb begin
        state_nx = state;
        key_load = 1'b0;
        key_inc  = 1'b0;
        if (abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_FOUND, ST_FAIL: begin
                    if (start) begin
                        state_nx = ST_INIT_GO;
                        key_load = 1'b1;
                    end
                end
                ST_INIT_GO:   state_nx = ST_INIT_WAIT;
                ST_INIT_WAIT: if (init_done) state_nx = ST_KSA_GO;
                ST_KSA_GO:    state_nx = ST_KSA_WAIT;
                ST_KSA_WAIT:  if (ksa_done) state_nx = ST_PRGA_GO;
                ST_PRGA_GO:   state_nx = ST_PRGA_WAIT;
                ST_PRGA_WAIT: begin
                    if (prga_done) begin
                        if (prga_pass) begin
                            state_nx = ST_FOUND;
                        end else if (key_is_last) begin
                            state_nx = ST_FAIL;
                        end else begin
                            state_nx = ST_INIT_GO;
                            key_inc  = 1'b1;
                        end
                    end
                end
                default:      state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        init_start_nx = (state_nx == ST_INIT_GO);
        ksa_start_nx  = (state_nx == ST_KSA_GO);
        prga_start_nx = (state_nx == ST_PRGA_GO);
        mem_sel_nx    = mem_sel_of(state_nx);
        busy_nx       = is_busy(state_nx);
        found_nx      = (state_nx == ST_FOUND);
        fail_nx       = (state_nx == ST_FAIL);
    end

endmodule

// File: tb/tb_key_search_ctrl.sv
// Bench for key_search_ctrl: two instances (default range and KEY_LAST=3),
// engine responders, a phase-level reference model and directed scenarios.
`timescale 1ns/1ps
module tb_key_search_ctrl;

    localparam int KW = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic start_v [2];
    logic abort_v [2];
    logic init_done_v [2];
    logic ksa_done_v [2];
    logic prga_done_v [2];
    logic prga_pass_v [2];
    logic [2:0] resp_done [2];
    logic       resp_pass [2];
    logic [2:0] stray_done [2];
    logic       stray_pass [2];
    logic       resp_en [2];
    int         pass_key [2];

    logic [KW-1:0] key_o [2];
    logic [1:0]    mem_sel_o [2];
    logic init_start_o [2];
    logic ksa_start_o [2];
    logic prga_start_o [2];
    logic busy_o [2];
    logic found_o [2];
    logic fail_o [2];

    for (genvar g = 0; g < 2; g++) begin : g_in
        assign init_done_v[g] = resp_done[g][0] | stray_done[g][0];
        assign ksa_done_v[g]  = resp_done[g][1] | stray_done[g][1];
        assign prga_done_v[g] = resp_done[g][2] | stray_done[g][2];
        assign prga_pass_v[g] = resp_pass[g] | stray_pass[g];
    end

    key_search_ctrl dut0 (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]), .abort(abort_v[0]),
        .key(key_o[0]), .init_start(init_start_o[0]), .ksa_start(ksa_start_o[0]),
        .prga_start(prga_start_o[0]), .init_done(init_done_v[0]), .ksa_done(ksa_done_v[0]),
        .prga_done(prga_done_v[0]), .prga_pass(prga_pass_v[0]), .mem_sel(mem_sel_o[0]),
        .busy(busy_o[0]), .found(found_o[0]), .fail(fail_o[0])
    );

    key_search_ctrl #(.KEY_LAST(24'h000003)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]), .abort(abort_v[1]),
        .key(key_o[1]), .init_start(init_start_o[1]), .ksa_start(ksa_start_o[1]),
        .prga_start(prga_start_o[1]), .init_done(init_done_v[1]), .ksa_done(ksa_done_v[1]),
        .prga_done(prga_done_v[1]), .prga_pass(prga_pass_v[1]), .mem_sel(mem_sel_o[1]),
        .busy(busy_o[1]), .found(found_o[1]), .fail(fail_o[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a search is either running (engine 0..2, launching or
    // waiting) or at rest with a result (0 none, 1 found, 2 fail).
    bit m_busy [2];
    bit m_go [2];
    int m_eng [2];
    int m_res [2];
    int m_key [2];

    function automatic int last_of(int i);
        return (i == 0) ? 32'h3FFFFF : 3;
    endfunction

    function automatic logic eng_done(int i, int e);
        case (e)
            0:       return init_done_v[i];
            1:       return ksa_done_v[i];
            default: return prga_done_v[i];
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_busy[i] = 0; m_go[i] = 0; m_eng[i] = 0; m_res[i] = 0; m_key[i] = 0;
            end else if (abort_v[i]) begin
                m_busy[i] = 0; m_go[i] = 0; m_res[i] = 0;
            end else if (!m_busy[i]) begin
                if (start_v[i]) begin
                    m_busy[i] = 1; m_go[i] = 1; m_eng[i] = 0; m_key[i] = 0; m_res[i] = 0;
                end
            end else if (m_go[i]) begin
                m_go[i] = 0;
            end else if (eng_done(i, m_eng[i])) begin
                if (m_eng[i] < 2) begin
                    m_eng[i] = m_eng[i] + 1; m_go[i] = 1;
                end else if (prga_pass_v[i]) begin
                    m_busy[i] = 0; m_res[i] = 1;
                end else if (m_key[i] == last_of(i)) begin
                    m_busy[i] = 0; m_res[i] = 2;
                end else begin
                    m_key[i] = m_key[i] + 1; m_eng[i] = 0; m_go[i] = 1;
                end
            end
        end
    end

    function automatic logic [31:0] exp_vec(int i);
        logic [1:0] ms;
        ms = m_busy[i] ? 2'(m_eng[i]) : 2'd3;
        return {KW'(m_key[i]), ms,
                m_busy[i] && m_go[i] && m_eng[i] == 0,
                m_busy[i] && m_go[i] && m_eng[i] == 1,
                m_busy[i] && m_go[i] && m_eng[i] == 2,
                m_busy[i],
                !m_busy[i] && m_res[i] == 1,
                !m_busy[i] && m_res[i] == 2};
    endfunction

    function automatic logic [31:0] act_vec(int i);
        return {key_o[i], mem_sel_o[i], init_start_o[i], ksa_start_o[i], prga_start_o[i],
                busy_o[i], found_o[i], fail_o[i]};
    endfunction

    logic chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (act_vec(i) !== exp_vec(i)) begin
                    n_bad++;
                    $display("FAIL model inst%0d t=%0t: got %h expected %h", i, $time, act_vec(i), exp_vec(i));
                end
            end
        end
    end

    // Engine responders, launch counters and mem_sel trace for instance 0.
    int n_init [2];
    int n_ksa [2];
    int n_prga [2];
    int t_init [2];
    int t_ksa [2];
    int t_prga [2];
    int rcnt [2];
    int reng [2];
    int cyc = 0;
    logic [1:0] ms_q[$];
    logic [1:0] ms_last = 2'd3;

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (init_start_o[i] === 1'b1) begin n_init[i]++; t_init[i] = cyc; end
            if (ksa_start_o[i] === 1'b1)  begin n_ksa[i]++;  t_ksa[i]  = cyc; end
            if (prga_start_o[i] === 1'b1) begin n_prga[i]++; t_prga[i] = cyc; end
            resp_done[i] = 3'b000;
            resp_pass[i] = 1'b0;
            if (!resp_en[i]) begin
                rcnt[i] = 0;
            end else begin
                if (rcnt[i] > 0) begin
                    rcnt[i]--;
                    if (rcnt[i] == 0) begin
                        resp_done[i][reng[i]] = 1'b1;
                        if (reng[i] == 2) resp_pass[i] = (int'(key_o[i]) == pass_key[i]);
                    end
                end
                if (init_start_o[i] === 1'b1) begin rcnt[i] = 4; reng[i] = 0; end
                if (ksa_start_o[i] === 1'b1)  begin rcnt[i] = 4; reng[i] = 1; end
                if (prga_start_o[i] === 1'b1) begin rcnt[i] = 4; reng[i] = 2; end
            end
        end
        if (mem_sel_o[0] !== ms_last) begin
            ms_q.push_back(mem_sel_o[0]);
            ms_last = mem_sel_o[0];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic sig(int i, int w);
        case (w)
            0:       return found_o[i];
            1:       return fail_o[i];
            2:       return init_start_o[i];
            3:       return ksa_start_o[i];
            default: return prga_start_o[i];
        endcase
    endfunction

    task automatic wait_sig(input int i, input int w, input int maxc, input string name);
        int c;
        c = 0;
        while (sig(i, w) !== 1'b1 && c < maxc) begin
            @(negedge clk); #1;
            c++;
        end
        check({name, " wait"}, 64'(sig(i, w)), 64'd1);
    endtask

    task automatic pulse_start(input int i);
        @(negedge clk); start_v[i] = 1'b1;
        @(negedge clk); start_v[i] = 1'b0;
    endtask

    localparam logic [31:0] RESET_VEC = {24'h000000, 2'd3, 6'b000000};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bi, bk, bp, bm;
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 0; abort_v[i] = 0; stray_done[i] = 3'b000; stray_pass[i] = 0;
            resp_en[i] = 1; pass_key[i] = -1;
        end
        @(posedge clk); #1;
        chk_en = 1'b1;
        check("reset outputs inst0", act_vec(0), RESET_VEC);
        check("reset outputs inst1", act_vec(1), RESET_VEC);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // First key accepted
        pass_key[0] = 0;
        bi = n_init[0]; bk = n_ksa[0]; bp = n_prga[0]; bm = ms_q.size();
        pulse_start(0);
        wait_sig(0, 0, 100, "first key found");
        check("first key value", key_o[0], 24'h000000);
        check("first key init pulses", n_init[0] - bi, 1);
        check("first key ksa pulses", n_ksa[0] - bk, 1);
        check("first key prga pulses", n_prga[0] - bp, 1);
        check("launch order", (t_init[0] < t_ksa[0]) && (t_ksa[0] < t_prga[0]), 1);
        check("mem_sel trace length", ms_q.size() - bm, 4);
        if (ms_q.size() - bm == 4)
            check("mem_sel trace", {ms_q[bm], ms_q[bm+1], ms_q[bm+2], ms_q[bm+3]}, 8'h1B);

        // Exhaust a four-key range
        bi = n_init[1]; bp = n_prga[1];
        pulse_start(1);
        wait_sig(1, 1, 300, "range fail");
        check("fail init pulses", n_init[1] - bi, 4);
        check("fail prga pulses", n_prga[1] - bp, 4);
        check("fail key holds last", key_o[1], 24'h000003);
        check("fail busy", busy_o[1], 0);

        // Accept key 5, restarting from FOUND
        pass_key[0] = 5;
        bi = n_init[0]; bp = n_prga[0];
        pulse_start(0);
        wait_sig(0, 0, 400, "key5 found");
        check("key5 value", key_o[0], 24'h000005);
        check("key5 prga pulses", n_prga[0] - bp, 6);
        check("key5 init pulses", n_init[0] - bi, 6);

        // Abort in KSA_WAIT coinciding with ksa_done
        resp_en[0] = 0;
        bk = n_ksa[0]; bp = n_prga[0];
        pulse_start(0);
        @(negedge clk); stray_done[0] = 3'b001;
        @(negedge clk); stray_done[0] = 3'b000;
        wait_sig(0, 3, 5, "abort ksa launch");
        @(negedge clk); abort_v[0] = 1; stray_done[0] = 3'b010;
        @(negedge clk); abort_v[0] = 0; stray_done[0] = 3'b000;
        #1;
        check("abort busy", busy_o[0], 0);
        check("abort mem_sel", mem_sel_o[0], 2'd3);
        check("abort key holds", key_o[0], 24'h000000);
        repeat (8) @(negedge clk);
        #1;
        check("abort prga pulses", n_prga[0] - bp, 0);
        check("abort ksa pulses", n_ksa[0] - bk, 1);

        // start while busy and done pulses in the wrong WAIT state
        bi = n_init[0]; bk = n_ksa[0]; bp = n_prga[0];
        pulse_start(0);
        @(negedge clk); start_v[0] = 1; stray_done[0] = 3'b110;
        @(negedge clk); start_v[0] = 0; stray_done[0] = 3'b000;
        repeat (3) @(negedge clk);
        #1;
        check("stray init mem_sel", mem_sel_o[0], 2'd0);
        check("stray init launches", {8'(n_init[0] - bi), 8'(n_ksa[0] - bk), 8'(n_prga[0] - bp)}, 24'h010000);
        stray_done[0] = 3'b001;
        @(negedge clk); stray_done[0] = 3'b000;
        wait_sig(0, 3, 5, "stray ksa launch");
        @(negedge clk); stray_done[0] = 3'b101; start_v[0] = 1;
        @(negedge clk); stray_done[0] = 3'b000; start_v[0] = 0;
        repeat (3) @(negedge clk);
        #1;
        check("stray ksa mem_sel", mem_sel_o[0], 2'd1);
        check("stray ksa launches", {8'(n_init[0] - bi), 8'(n_ksa[0] - bk), 8'(n_prga[0] - bp)}, 24'h010100);
        abort_v[0] = 1;
        @(negedge clk); abort_v[0] = 0;

        // Reset during PRGA_WAIT, stray prga_done afterwards
        resp_en[0] = 1; pass_key[0] = -1;
        pulse_start(0);
        wait_sig(0, 4, 100, "reset prga launch");
        @(negedge clk);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("async reset inst0", act_vec(0), RESET_VEC);
        check("async reset inst1", act_vec(1), RESET_VEC);
        @(negedge clk); resp_en[0] = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); stray_done[0] = 3'b100; stray_pass[0] = 1;
        @(negedge clk); stray_done[0] = 3'b000; stray_pass[0] = 0;
        repeat (5) @(negedge clk);
        #1;
        check("post reset stray prga", act_vec(0), RESET_VEC);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_search_ctrl.md
KEY_SEARCH_CTRL -- requirements
Module: key_search_ctrl

Interface
REQ-001 SHALL have parameter KEY_W, default 24: key width in bits.
REQ-002 SHALL have parameter KEY_FIRST, default 24'h000000: first key tried.
REQ-003 SHALL have parameter KEY_LAST, default 24'h3FFFFF: last key tried.
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin a search; sampled only in IDLE, FOUND, FAIL.
REQ-007 abort  in  1  synchronous abort to IDLE from any state.
REQ-008 key  out  KEY_W  key currently under test, driven to all engines.
REQ-009 init_start / ksa_start / prga_start  out  1 each  one-cycle launch pulses to the init, swap (KSA) and decrypt (PRGA) engines.
REQ-010 init_done / ksa_done / prga_done  in  1 each  one-cycle completion pulses from those engines.
REQ-011 prga_pass  in  1  decrypted message valid; meaningful only while prga_done=1.
REQ-012 mem_sel  out  2  S-memory port owner: 0=init, 1=KSA, 2=PRGA, 3=none (writes gated).
REQ-013 busy / found / fail  out  1 each  search status.

Function
REQ-014 SHALL implement states IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO, PRGA_WAIT, FOUND, FAIL.
REQ-015 IDLE/FOUND/FAIL + start=1 -> INIT_GO next cycle; key <= KEY_FIRST on that edge.
REQ-016 Each *_GO state SHALL last exactly one cycle, assert its *_start=1, then enter the matching *_WAIT.
REQ-017 INIT_WAIT + init_done -> KSA_GO; KSA_WAIT + ksa_done -> PRGA_GO.
REQ-018 PRGA_WAIT + prga_done + prga_pass=1 -> FOUND; key holds.
REQ-019 PRGA_WAIT + prga_done + prga_pass=0 + key!=KEY_LAST -> INIT_GO with key <= key+1.
REQ-020 PRGA_WAIT + prga_done + prga_pass=0 + key==KEY_LAST -> FAIL; key holds, no wrap to 0.
REQ-021 Done pulses arriving in any state other than their own *_WAIT SHALL be ignored.
REQ-022 mem_sel SHALL be 0 in INIT_*, 1 in KSA_*, 2 in PRGA_*, 3 elsewhere; registered, changes same edge as state.
REQ-023 busy=1 in every *_GO/*_WAIT state, else 0; found=1 only in FOUND; fail=1 only in FAIL.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 abort=1 SHALL move any state to IDLE next cycle, winning over simultaneous start or done; key holds.
REQ-026 All outputs SHALL be registered; *_start rises exactly one cycle after the edge entering the GO state is decided (launch latency 1 cycle from causing event).
REQ-027 Minimum per-key overhead: 3 controller cycles (three GO states) plus engine latencies.

Reset
REQ-028 reset_n=0 SHALL immediately force state=IDLE, key=KEY_FIRST, mem_sel=3, all *_start=0, busy=found=fail=0.
REQ-029 Reset asserted mid-search SHALL discard progress; no done pulse after release advances state without a new start.

Structure
REQ-030 State enum, mem_sel encodings (MEM_INIT, MEM_KSA, MEM_PRGA, MEM_NONE) and KEY_W default SHALL live in shared package rc4_pkg.
REQ-031 Key register/incrementer with load, inc and last-key compare SHALL be sub-module key_counter; FSM stays in key_search_ctrl.

Verification
REQ-032 start pulse, engines reply done after 4 cycles, prga_pass=1 on first key -> init/ksa/prga_start each pulse once in order, mem_sel 0->1->2->3, found=1, key=0x000000.
REQ-033 KEY_LAST=3, prga_pass=0 always -> keys 0,1,2,3 tried (4 init_start pulses), then fail=1, key=3, busy=0.
REQ-034 prga_pass=1 on key 0x000005 -> found=1, key=0x000005, exactly 6 prga_start pulses.
REQ-035 abort in KSA_WAIT together with ksa_done -> IDLE next cycle, no prga_start, mem_sel=3.
REQ-036 reset_n low during PRGA_WAIT, stray prga_done after release -> stays IDLE, all outputs at reset values.
REQ-037 start pulse during busy and done pulse in wrong WAIT state -> no state change, no extra launch pulses.
